// File: rtl/delay_lap_ctrl.sv
// Run-time tap controller for the pixel delay line: accepts clamped tap requests, applies them
// at line boundaries, tracks refill settling and measures the active line length.
module delay_lap_ctrl #(
  parameter int unsigned MAX_DELAY_LAPS = 640,
  parameter int unsigned LAP_W          = 10,
  parameter int unsigned INIT_LAP       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_de,
  input  logic             cfg_valid,
  input  logic [LAP_W-1:0] cfg_lap,
  output logic             cfg_ready,
  output logic [LAP_W-1:0] delaylap,
  output logic             o_tap_stable,
  output logic             o_pending,
  output logic             o_cfg_err,
  output logic [15:0]      o_line_len
);

  localparam logic [LAP_W-1:0] MaxLap  = LAP_W'(MAX_DELAY_LAPS);
  localparam logic [LAP_W-1:0] InitLap = LAP_W'(INIT_LAP);

  typedef enum logic [1:0] {StIdle, StPend, StSettle} state_e;

  state_e           state_q, state_d;
  logic [LAP_W-1:0] pend_lap_q, pend_lap_d;
  logic [LAP_W-1:0] delaylap_q, delaylap_d;
  logic [LAP_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             stable_q, stable_d;
  logic             cfg_err_q, cfg_err_d;
  logic             de_d_q;
  logic [15:0]      pix_cnt_q, pix_cnt_d;
  logic [15:0]      line_len_q, line_len_d;
  logic             de_fall;
  logic             lap_over;

  assign de_fall  = de_d_q & ~i_de;
  assign lap_over = cfg_lap > MaxLap;

  always_comb begin
    state_d      = state_q;
    pend_lap_d   = pend_lap_q;
    delaylap_d   = delaylap_q;
    settle_cnt_d = settle_cnt_q;
    stable_d     = stable_q;
    cfg_err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          pend_lap_d = lap_over ? MaxLap : cfg_lap;
          cfg_err_d  = lap_over;
          state_d    = StPend;
        end
      end
      StPend: begin
        if (de_fall) begin
          delaylap_d   = pend_lap_q;
          settle_cnt_d = pend_lap_q;
          stable_d     = 1'b0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        // Terminal-count cycle included, so the output is unstable for tap+1 cycles.
        if (settle_cnt_q == '0) begin
          stable_d = 1'b1;
          state_d  = StIdle;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_len_d = line_len_q;
    if (de_fall) begin
      line_len_d = pix_cnt_q;
      pix_cnt_d  = '0;
    end else if (i_de && (pix_cnt_q != 16'hFFFF)) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pend_lap_q   <= '0;
      delaylap_q   <= InitLap;
      settle_cnt_q <= '0;
      stable_q     <= 1'b1;
      cfg_err_q    <= 1'b0;
      de_d_q       <= 1'b0;
      pix_cnt_q    <= '0;
      line_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_lap_q   <= pend_lap_d;
      delaylap_q   <= delaylap_d;
      settle_cnt_q <= settle_cnt_d;
      stable_q     <= stable_d;
      cfg_err_q    <= cfg_err_d;
      de_d_q       <= i_de;
      pix_cnt_q    <= pix_cnt_d;
      line_len_q   <= line_len_d;
    end
  end

  assign cfg_ready    = (state_q == StIdle);
  assign o_pending    = (state_q == StPend);
  assign delaylap     = delaylap_q;
  assign o_tap_stable = stable_q;
  assign o_cfg_err    = cfg_err_q;
  assign o_line_len   = line_len_q;

endmodule

// File: tb/tb_delay_lap_ctrl.sv
// Self-checking bench for delay_lap_ctrl: directed scenarios plus randomized traffic against a
// timestamp-based reference model.
module tb_delay_lap_ctrl;

  localparam int MaxLaps = 640;
  localparam int InitLap = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_de = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [9:0] cfg_lap = '0;
  logic       cfg_ready;
  logic [9:0] delaylap;
  logic       o_tap_stable;
  logic       o_pending;
  logic       o_cfg_err;
  logic [15:0] o_line_len;

  int checks = 0;
  int errors = 0;

  // Reference model: edge count n, tap stable once n reaches m_stable_at.
  int m_n, m_stable_at, m_lap, m_pend_lap, m_line, m_pix;
  bit m_pend, m_err, m_de_prev;

  delay_lap_ctrl #(
    .MAX_DELAY_LAPS(MaxLaps),
    .LAP_W         (10),
    .INIT_LAP      (InitLap)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_de        (i_de),
    .cfg_valid   (cfg_valid),
    .cfg_lap     (cfg_lap),
    .cfg_ready   (cfg_ready),
    .delaylap    (delaylap),
    .o_tap_stable(o_tap_stable),
    .o_pending   (o_pending),
    .o_cfg_err   (o_cfg_err),
    .o_line_len  (o_line_len)
  );

  always #5 clk = ~clk;

  function automatic bit exp_stable();
    return m_n >= m_stable_at;
  endfunction

  function automatic bit exp_ready();
    return !m_pend && exp_stable();
  endfunction

  task automatic model_reset();
    m_n = 0; m_stable_at = 0; m_lap = InitLap; m_pend_lap = 0;
    m_line = 0; m_pix = 0; m_pend = 0; m_err = 0; m_de_prev = 0;
  endtask

  // One rising edge; the model consumes the inputs seen at that edge. Ends 1 time unit later.
  task automatic tick();
    bit rdy, pnd, fall, de, vld;
    int lap;
    rdy = exp_ready(); pnd = m_pend;
    de = i_de; vld = cfg_valid; lap = int'(cfg_lap);
    fall = m_de_prev && !de;
    @(posedge clk);
    m_n++;
    m_err = 0;
    if (rdy && vld) begin
      m_pend = 1;
      m_pend_lap = (lap > MaxLaps) ? MaxLaps : lap;
      m_err = lap > MaxLaps;
    end else if (pnd && fall) begin
      m_pend = 0;
      m_lap = m_pend_lap;
      m_stable_at = m_n + m_pend_lap + 1;
    end
    if (fall) begin
      m_line = m_pix; m_pix = 0;
    end else if (de && m_pix < 65535) begin
      m_pix++;
    end
    m_de_prev = de;
    #1;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    i_de = 1'b0; cfg_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic request(input int lap);
    cfg_lap = 10'(lap); cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (delaylap !== 10'(InitLap)) begin
      errors++; $display("FAIL reset_delaylap: got %0d want %0d", delaylap, InitLap);
    end
    if (o_tap_stable !== 1'b1) begin errors++; $display("FAIL reset_stable: got %b want 1", o_tap_stable); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    if (o_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", o_pending); end
    if (o_line_len !== 16'd0) begin errors++; $display("FAIL reset_line_len: got %0d want 0", o_line_len); end
    // Mid-line reset with a request pending and a completed line recorded.
    i_de = 1'b1; repeat (12) tick();
    i_de = 1'b0; tick();
    i_de = 1'b1; repeat (5) tick();
    request(30);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (delaylap !== 10'(InitLap)) begin
      errors++; $display("FAIL midline_reset_delaylap: got %0d want %0d", delaylap, InitLap);
    end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midline_reset_ready: got %b want 1", cfg_ready); end
    if (o_pending !== 1'b0) begin errors++; $display("FAIL midline_reset_pending: got %b want 0", o_pending); end
    if (o_line_len !== 16'd0) begin
      errors++; $display("FAIL midline_reset_line_len: got %0d want 0", o_line_len);
    end
    model_reset(); i_de = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_change(input string name, input int lap, input int want_lap);
    int cnt;
    i_de = 1'b1; repeat (10) tick();
    request(lap);
    checks += 3;
    if (o_pending !== 1'b1) begin errors++; $display("FAIL %s_pending: got %b want 1", name, o_pending); end
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_low: got %b want 0", name, cfg_ready); end
    if (o_cfg_err !== (lap > MaxLaps)) begin
      errors++; $display("FAIL %s_cfg_err: got %b want %b", name, o_cfg_err, lap > MaxLaps);
    end
    tick();
    checks++;
    if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL %s_cfg_err_clear: got %b want 0", name, o_cfg_err); end
    repeat (48) tick();
    i_de = 1'b0; tick();
    checks += 2;
    if (delaylap !== 10'(want_lap)) begin
      errors++; $display("FAIL %s_delaylap: got %0d want %0d", name, delaylap, want_lap);
    end
    if (o_tap_stable !== 1'b0) begin errors++; $display("FAIL %s_stable_low: got %b want 0", name, o_tap_stable); end
    cnt = 0;
    while (o_tap_stable === 1'b0 && cnt < 5000) begin cnt++; tick(); end
    checks += 2;
    if (cnt != want_lap + 1) begin
      errors++; $display("FAIL %s_settle_cycles: got %0d want %0d", name, cnt, want_lap + 1);
    end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_back: got %b want 1", name, cfg_ready); end
  endtask

  task automatic test_basic_change();
    run_change("basic", 100, 100);
  endtask

  task automatic test_clamp();
    run_change("clamp", 1000, MaxLaps);
  endtask

  task automatic test_back_to_back();
    int cnt;
    i_de = 1'b1; repeat (4) tick();
    request(5);
    cfg_lap = 10'd7; cfg_valid = 1'b1;
    repeat (3) tick();
    i_de = 1'b0; tick();
    cnt = 0;
    while (o_tap_stable === 1'b0 && cnt < 100) begin
      checks++;
      if (o_pending !== 1'b0 || delaylap !== 10'd5) begin
        errors++;
        $display("FAIL b2b_held_off: pending %b lap %0d want 0 and 5", o_pending, delaylap);
      end
      cnt++; tick();
    end
    checks++;
    if (cnt != 6) begin errors++; $display("FAIL b2b_settle_cycles: got %0d want 6", cnt); end
    tick();
    cfg_valid = 1'b0;
    checks += 2;
    if (o_pending !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", o_pending); end
    if (delaylap !== 10'd5) begin errors++; $display("FAIL b2b_lap_hold: got %0d want 5", delaylap); end
    i_de = 1'b1; repeat (2) tick();
    i_de = 1'b0; tick();
    checks++;
    if (delaylap !== 10'd7) begin errors++; $display("FAIL b2b_second_lap: got %0d want 7", delaylap); end
    repeat (10) tick();
  endtask

  task automatic test_line_len();
    int lens[2] = '{640, 320};
    foreach (lens[k]) begin
      i_de = 1'b1; repeat (lens[k]) tick();
      i_de = 1'b0; tick();
      checks++;
      if (o_line_len !== 16'(lens[k])) begin
        errors++; $display("FAIL line_len_%0d: got %0d want %0d", k, o_line_len, lens[k]);
      end
      repeat (7) tick();
    end
  endtask

  task automatic test_reset_settle();
    i_de = 1'b1; repeat (5) tick();
    request(200);
    i_de = 1'b0; tick();
    repeat (20) tick();
    checks++;
    if (o_tap_stable !== 1'b0) begin errors++; $display("FAIL rs_settling: got %b want 0", o_tap_stable); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (delaylap !== 10'(InitLap)) begin
      errors++; $display("FAIL rs_delaylap: got %0d want %0d", delaylap, InitLap);
    end
    if (o_tap_stable !== 1'b1) begin errors++; $display("FAIL rs_stable: got %b want 1", o_tap_stable); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rs_ready: got %b want 1", cfg_ready); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    int run = 0;
    for (int c = 0; c < 6000; c++) begin
      if (run == 0) begin
        i_de = ~i_de;
        run = i_de ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 20));
      end
      run--;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_lap = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'($urandom_range(0, 30));
      tick();
      checks += 6;
      if (cfg_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready @%0d: got %b want %b", c, cfg_ready, exp_ready());
      end
      if (o_pending !== m_pend) begin
        errors++; $display("FAIL rnd_pending @%0d: got %b want %b", c, o_pending, m_pend);
      end
      if (o_tap_stable !== exp_stable()) begin
        errors++; $display("FAIL rnd_stable @%0d: got %b want %b", c, o_tap_stable, exp_stable());
      end
      if (delaylap !== 10'(m_lap)) begin
        errors++; $display("FAIL rnd_delaylap @%0d: got %0d want %0d", c, delaylap, m_lap);
      end
      if (o_cfg_err !== m_err) begin
        errors++; $display("FAIL rnd_cfg_err @%0d: got %b want %b", c, o_cfg_err, m_err);
      end
      if (o_line_len !== 16'(m_line)) begin
        errors++; $display("FAIL rnd_line_len @%0d: got %0d want %0d", c, o_line_len, m_line);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_change();
    test_clamp();
    test_back_to_back();
    test_line_len();
    test_reset_settle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
